axil_master_port: RTL
=====================

Name: axil_master_port

Overview:
- Parametrised AXI4-Lite master front-end that converts user write/read commands into fully handshaked AW/W/B and AR/R transactions.
- Write and read engines are independent and may run concurrently.
- AW and W are handshaked independently, so the slave may accept them in either order or in the same cycle.
- Sits between HLS-generated datapaths and a shared AXI-Lite slave (e.g. axil_ram); a one-cycle done pulse returns the response code and read data.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- ADDR_WIDTH, 5, address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width (derived; do not override).
- TIMEOUT_CYCLES, 256, response-wait limit in cycles; used only with AXIL_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  user write request
- wr_ready  out  1  write engine idle; request accepted when wr_valid&&wr_ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_strb  in  STRB_WIDTH  byte enables
- wr_done  out  1  one-cycle pulse: write complete
- wr_resp  out  2  BRESP of the completed write; valid while wr_done=1
- rd_valid  in  1  user read request
- rd_ready  out  1  read engine idle
- rd_addr  in  ADDR_WIDTH  read address
- rd_done  out  1  one-cycle pulse: read complete
- rd_data  out  DATA_WIDTH  captured RDATA; held until the next rd_done
- rd_resp  out  2  captured RRESP; held until the next rd_done
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1; m_axil_awready  in  1
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1; m_axil_wready  in  1
- m_axil_bresp  in  2; m_axil_bvalid  in  1; m_axil_bready  out  1
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1; m_axil_arready  in  1
- m_axil_rdata  in  DATA_WIDTH; m_axil_rresp  in  2; m_axil_rvalid  in  1; m_axil_rready  out  1
- wr_timeout, rd_timeout  out  1  sticky timeout flags (tied 0 without the macro)

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ready=rd_ready=1.
  - All valids, bready, rready, done, resp, timeout flags = 0.
  - rd_data, awaddr, wdata, araddr, wstrb = 0.
  - awprot=arprot=3'b000 (constant).
  - An in-flight transaction is abandoned; the slave is reset by the same rst_n.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE: wr_ready=1. On wr_valid, register addr/data/strb, set awvalid=wvalid=1 and go to W_SEND (wr_ready=0 from the next cycle).
  - W_SEND: awvalid drops in the cycle after awvalid&&awready; wvalid drops in the cycle after wvalid&&wready; these are independent. When both handshakes are complete (same or different cycles), go to W_RESP with bready=1.
  - Valid/addr/data never change while valid is high and ready is low.
  - W_RESP: on bvalid&&bready, wr_resp<=bresp, wr_done=1 for one cycle, bready<=0, go to W_IDLE.
  - Any bvalid seen outside W_RESP is ignored; bready is 0 there.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: on rd_valid, latch rd_addr into araddr, set arvalid=1, go to R_ADDR.
  - R_ADDR: arvalid drops in the cycle after arready; go to R_DATA with rready=1.
  - R_DATA: on rvalid, capture rdata/rresp, rd_done=1 for one cycle, rready<=0, go to R_IDLE.
- Latency: with an always-ready slave that returns B/R one cycle after the address handshake, a request accepted at edge N gives done at edge N+3.
- Back-to-back operation: a new request may be accepted in the cycle in which done is high; there is one idle cycle minimum between transactions.
- Concurrency: simultaneous wr_valid and rd_valid are both accepted in the same cycle; there is no ordering guarantee between reads and writes.
- Nonzero responses (SLVERR/DECERR) complete normally; only the resp code reports the error.

Optional Feature:
- Macro: AXIL_TIMEOUT_EN.
- Defined:
  - A per-engine counter, width $clog2(TIMEOUT_CYCLES)+1, clears on entry to W_SEND or R_ADDR and counts every cycle until done.
  - When the counter reaches TIMEOUT_CYCLES, the engine:
    - drops all its valids and readies;
    - pulses done with resp=2'b10;
    - sets its sticky wr_timeout or rd_timeout flag;
    - enters a locked state with its ready held at 0 until rst_n.
  - The other engine is unaffected.
- Undefined: no counter is present, timeout outputs are tied 0, and the engines wait indefinitely.

Test Plan:
- Write addr=1 data=2345 strb=4'hF to axil_ram, then read addr=1 -> wr_done with wr_resp=0; rd_done with rd_data=2345 and rd_resp=0.
- Slave stalls awready 3 cycles with wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles with stable awaddr, exactly one wr_done.
- Write strb=4'b0011 data=32'hAABBCCDD over 32'h11223344 at addr 4 -> readback 32'h1122CCDD.
- Simultaneous write addr=2 data=7 and read addr=3 (preloaded 9) -> both accepted in the same cycle; rd_data=9 and a later read of addr 2 returns 7.
- Deassert rst_n while in W_RESP -> all outputs take reset values immediately, without waiting for a clock edge; wr_ready=1 after release.
- With AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never asserts bvalid -> wr_done on cycle 8 with wr_resp=2'b10, wr_timeout=1, wr_ready stays 0, reads still complete.

Source files
------------

// File: rtl/axil_master_port.sv
// axil_master_port: AXI4-Lite master front-end with independent write
// (AW/W/B) and read (AR/R) engines driven by a simple valid/ready command
// interface. Each completed transaction returns a one-cycle done pulse with
// the response code (and read data for reads).
// Optional feature: define AXIL_TIMEOUT_EN to add a per-engine response
// watchdog that aborts a stuck transaction with resp=2'b10 and locks that
// engine until reset.
module axil_master_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // user write command
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  wr_done,
  output logic [1:0]            wr_resp,
  // user read command
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  // sticky watchdog flags
  output logic                  wr_timeout,
  output logic                  rd_timeout
);

  // W_LOCK / R_LOCK are only reachable when the watchdog is built in.
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP, W_LOCK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_LOCK} r_state_t;

  w_state_t              w_state_q;
  r_state_t              r_state_q;

  logic                  wr_ready_q, wr_done_q, awvalid_q, wvalid_q, bready_q;
  logic [1:0]            wr_resp_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic                  rd_ready_q, rd_done_q, arvalid_q, rready_q;
  logic [1:0]            rd_resp_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // AW and W complete independently; a dropped valid inside W_SEND means
  // that channel has already handshaked.
  logic aw_hs, w_hs, aw_ok, w_ok;
  assign aw_hs = awvalid_q & m_axil_awready;
  assign w_hs  = wvalid_q & m_axil_wready;
  assign aw_ok = aw_hs | ~awvalid_q;
  assign w_ok  = w_hs | ~wvalid_q;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_timeout_q, rd_timeout_q;
  logic             wr_expire, rd_expire;

  assign wr_cnt_d = wr_cnt_q + CNT_W'(1);
  assign rd_cnt_d = rd_cnt_q + CNT_W'(1);

  // A response arriving in the expiry cycle still completes normally.
  assign wr_expire = (w_state_q == W_SEND || w_state_q == W_RESP) &&
                     (wr_cnt_d == CNT_LIMIT) &&
                     !(w_state_q == W_RESP && m_axil_bvalid);
  assign rd_expire = (r_state_q == R_ADDR || r_state_q == R_DATA) &&
                     (rd_cnt_d == CNT_LIMIT) &&
                     !(r_state_q == R_DATA && m_axil_rvalid);

  assign wr_timeout = wr_timeout_q;
  assign rd_timeout = rd_timeout_q;
`else
  // The limit only sizes the optional watchdog; referenced here so the
  // parameter remains part of the elaborated design in every build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end

  assign wr_timeout = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  // Write engine: capture command, run AW and W handshakes, wait for B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      wr_ready_q <= 1'b1;
      wr_done_q  <= 1'b0;
      wr_resp_q  <= 2'b00;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
`ifdef AXIL_TIMEOUT_EN
      wr_cnt_q     <= '0;
      wr_timeout_q <= 1'b0;
`endif
    end else begin
      wr_done_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (wr_valid) begin
            awaddr_q   <= wr_addr;
            wdata_q    <= wr_data;
            wstrb_q    <= wr_strb;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            wr_ready_q <= 1'b0;
            w_state_q  <= W_SEND;
          end
        end
        W_SEND: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axil_bvalid) begin
            wr_resp_q  <= m_axil_bresp;
            wr_done_q  <= 1'b1;
            bready_q   <= 1'b0;
            wr_ready_q <= 1'b1;
            w_state_q  <= W_IDLE;
          end
        end
        default: ;  // W_LOCK: parked until reset
      endcase
`ifdef AXIL_TIMEOUT_EN
      if (w_state_q == W_IDLE)      wr_cnt_q <= '0;
      else if (w_state_q != W_LOCK) wr_cnt_q <= wr_cnt_d;
      if (wr_expire) begin
        awvalid_q    <= 1'b0;
        wvalid_q     <= 1'b0;
        bready_q     <= 1'b0;
        wr_done_q    <= 1'b1;
        wr_resp_q    <= 2'b10;
        wr_timeout_q <= 1'b1;
        w_state_q    <= W_LOCK;
      end
`endif
    end
  end

  // Read engine: issue AR, then accept one R beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      rd_ready_q <= 1'b1;
      rd_done_q  <= 1'b0;
      rd_resp_q  <= 2'b00;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      rdata_q    <= '0;
`ifdef AXIL_TIMEOUT_EN
      rd_cnt_q     <= '0;
      rd_timeout_q <= 1'b0;
`endif
    end else begin
      rd_done_q <= 1'b0;
      case (r_state_q)
        R_IDLE: begin
          if (rd_valid) begin
            araddr_q   <= rd_addr;
            arvalid_q  <= 1'b1;
            rd_ready_q <= 1'b0;
            r_state_q  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axil_rvalid) begin
            rdata_q    <= m_axil_rdata;
            rd_resp_q  <= m_axil_rresp;
            rd_done_q  <= 1'b1;
            rready_q   <= 1'b0;
            rd_ready_q <= 1'b1;
            r_state_q  <= R_IDLE;
          end
        end
        default: ;  // R_LOCK: parked until reset
      endcase
`ifdef AXIL_TIMEOUT_EN
      if (r_state_q == R_IDLE)      rd_cnt_q <= '0;
      else if (r_state_q != R_LOCK) rd_cnt_q <= rd_cnt_d;
      if (rd_expire) begin
        arvalid_q    <= 1'b0;
        rready_q     <= 1'b0;
        rd_done_q    <= 1'b1;
        rd_resp_q    <= 2'b10;
        rd_timeout_q <= 1'b1;
        r_state_q    <= R_LOCK;
      end
`endif
    end
  end

  assign wr_ready       = wr_ready_q;
  assign wr_done        = wr_done_q;
  assign wr_resp        = wr_resp_q;
  assign rd_ready       = rd_ready_q;
  assign rd_done        = rd_done_q;
  assign rd_data        = rdata_q;
  assign rd_resp        = rd_resp_q;

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule
